// File: rtl/register_bank_beat_wr_pkg.sv
// Shared types and default widths for the beat-written register bank.
// No logic; package only.
// No backpressure; package only.
package register_bank_beat_wr_pkg;

    localparam int DEF_REG_WIDTH = 64;
    localparam int DEF_BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/register_bank_beat_wr_if.sv
// Beat write bus: valid/ready handshake plus abort and completion pulses.
// No latency; wires only.
// The slave throttles the master through wr_ready.
interface register_bank_beat_wr_if
    import register_bank_beat_wr_pkg::*;
#(
    parameter int ADDR_W    = 2,
    parameter int BUS_WIDTH = DEF_BUS_WIDTH
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_W-1:0]    wr_addr;
    logic [BUS_WIDTH-1:0] wr_data;
    logic                 wr_abort;
    logic                 wr_done;
    logic                 wr_err;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_abort,
        input  wr_ready, wr_done, wr_err
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_abort,
        output wr_ready, wr_done, wr_err
    );
endinterface

// File: rtl/register_bank_beat_wr_word.sv
// One wide register with synchronous active-high reset and load enable.
// Latency: q follows d one cycle after load.
// No backpressure; load is obeyed unconditionally.
module register_word_r_en #(
    parameter int REG_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [REG_WIDTH-1:0] d,
    output logic [REG_WIDTH-1:0] q
);
    // Hold value unless loaded; reset wins over load.
    always_ff @(posedge clk) begin
        if (reset)     q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/register_bank_beat_wr.sv
// Bank of NUM_REGS wide registers written as BEATS narrow beats, committed atomically.
// Latency: last beat at t+BEATS-1, COMMIT at t+BEATS, d_out and wr_done at t+BEATS+1.
// wr_ready drops for the single COMMIT cycle and during reset. Optional readback: REGBANK_READBACK_EN.
module register_bank_beat_wr
    import register_bank_beat_wr_pkg::*;
#(
    parameter int NUM_REGS  = 3,
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    localparam int BEATS    = REG_WIDTH / BUS_WIDTH,
    localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    register_bank_beat_wr_if.slave        wr,
    output logic                          busy,
    output logic [NUM_REGS*REG_WIDTH-1:0] d_out
`ifdef REGBANK_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [REG_WIDTH-1:0]          rd_data
`endif
);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     beat_cnt;
    logic [ADDR_W-1:0]    addr_q;
    logic [REG_WIDTH-1:0] shadow;
    logic                 done_q, err_q;
    logic                 accept, commit, in_range;
    logic [REG_WIDTH-1:0] regs [NUM_REGS];

    assign in_range   = (32'(addr_q) < NUM_REGS);
    assign wr.wr_done = done_q;
    assign wr.wr_err  = err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: abort only matters in FILL and beats the final beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (BEATS == 1) ? COMMIT : FILL;
            FILL:    if (wr.wr_abort)                         state_nxt = IDLE;
                     else if (accept && beat_cnt == LAST_BEAT) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; ready is forced low while reset is held.
    always_comb begin
        wr.wr_ready = !reset && (state != COMMIT);
        busy        = (state != IDLE);
        commit      = (state == COMMIT);
        accept      = wr.wr_valid && wr.wr_ready;
    end

    // Shadow collection, target latch and completion pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow   <= '0;
            beat_cnt <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q                  <= wr.wr_addr;
                        shadow[BUS_WIDTH-1:0]   <= wr.wr_data;
                        beat_cnt                <= CNT_W'(1);
                    end
                end
                FILL: begin
                    if (wr.wr_abort) begin
                        shadow   <= '0;
                        beat_cnt <= '0;
                    end else if (accept) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_cnt == CNT_W'(k))
                                shadow[k*BUS_WIDTH +: BUS_WIDTH] <= wr.wr_data;
                        end
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    done_q   <= in_range;
                    err_q    <= !in_range;
                    beat_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // One storage word per register; only the addressed word loads on commit.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        register_word_r_en #(.REG_WIDTH(REG_WIDTH)) u_word (
            .clk   (clk),
            .reset (reset),
            .load  (commit && (32'(addr_q) == i)),
            .d     (shadow),
            .q     (regs[i])
        );
        assign d_out[i*REG_WIDTH +: REG_WIDTH] = regs[i];
    end

`ifdef REGBANK_READBACK_EN
    logic [REG_WIDTH-1:0] rd_next;

    // Read mux; unmatched addresses read as zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_addr) == i) rd_next = regs[i];
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= rd_next;
    end
`endif
endmodule

// File: tb/tb_register_bank_beat_wr.sv
// Randomised and directed bench for register_bank_beat_wr against a transaction-level model.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at the same point.
// Honours REGBANK_READBACK_EN when defined.
module tb_register_bank_beat_wr;

    logic         clk = 1'b0;
    logic         reset;
    logic         busy;
    logic [191:0] d_out;
`ifdef REGBANK_READBACK_EN
    logic [1:0]   rd_addr;
    logic [63:0]  rd_data;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Expected register contents; entry 3 is a sink for out-of-range writes and never checked.
    logic [63:0] mdl [4];

    register_bank_beat_wr_if #(.ADDR_W(2), .BUS_WIDTH(32)) bus ();

    register_bank_beat_wr #(.NUM_REGS(3), .REG_WIDTH(64), .BUS_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .wr    (bus),
        .busy  (busy),
        .d_out (d_out)
`ifdef REGBANK_READBACK_EN
        ,
        .rd_addr (rd_addr),
        .rd_data (rd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reg%0d_%s", i, tag), d_out[i*64 +: 64], mdl[i]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) mdl[i] = '0;
    endtask

    // mode 0: full write; 1: abort after beat 0; 2: abort together with a valid beat.
    task automatic xfer(input logic [1:0] a, input logic [63:0] v, input int gap, input int mode);
        chk("ready_idle", 64'(bus.wr_ready), 64'(1));
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = v[31:0];
        bus.wr_abort = 1'($urandom_range(0, 1));
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_abort = 1'b0;
        bus.wr_addr  = 2'($urandom);
        bus.wr_data  = $urandom;
        chk("busy_fill", 64'(busy), 64'(1));
        for (int g = 0; g < gap; g++) begin
            tick();
            chk("busy_gap", 64'(busy), 64'(1));
            chk_regs("gap");
        end
        if (mode != 0) begin
            bus.wr_abort = 1'b1;
            bus.wr_valid = (mode == 2);
            bus.wr_data  = v[63:32];
            tick();
            bus.wr_abort = 1'b0;
            bus.wr_valid = 1'b0;
            chk("busy_abort", 64'(busy), 64'(0));
            chk("done_abort", 64'(bus.wr_done), 64'(0));
            chk_regs("abort");
            tick();
            chk("done_abort2", 64'(bus.wr_done), 64'(0));
            chk("err_abort2", 64'(bus.wr_err), 64'(0));
            return;
        end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 2'($urandom);
        bus.wr_data  = v[63:32];
        tick();
        // COMMIT cycle: a stray valid here must not be taken.
        bus.wr_valid = 1'($urandom_range(0, 1));
        bus.wr_data  = $urandom;
        chk("ready_commit", 64'(bus.wr_ready), 64'(0));
        chk("busy_commit", 64'(busy), 64'(1));
        chk("done_early", 64'(bus.wr_done), 64'(0));
        chk_regs("commit");
        tick();
        bus.wr_valid = 1'b0;
        mdl[a] = (a < 2'd3) ? v : mdl[a];
        chk("done", 64'(bus.wr_done), 64'(a < 2'd3));
        chk("err", 64'(bus.wr_err), 64'(a >= 2'd3));
        chk("busy_post", 64'(busy), 64'(0));
        chk("ready_post", 64'(bus.wr_ready), 64'(1));
        chk_regs("post");
        tick();
        chk("done_pulse", 64'(bus.wr_done), 64'(0));
        chk("err_pulse", 64'(bus.wr_err), 64'(0));
    endtask

    initial begin
        reset        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_abort = 1'b0;
`ifdef REGBANK_READBACK_EN
        rd_addr = '0;
`endif
        clear_model();
        tick();
        tick();
        chk("ready_in_reset", 64'(bus.wr_ready), 64'(0));
        chk("busy_reset", 64'(busy), 64'(0));
        chk("done_reset", 64'(bus.wr_done), 64'(0));
        chk("err_reset", 64'(bus.wr_err), 64'(0));
        chk_regs("reset");
        reset = 1'b0;
        tick();

        // Basic write, gapped write, abort then rewrite, out-of-range write.
        xfer(2'd1, 64'h0123456789ABCDEF, 0, 0);
        chk("reg1_first", d_out[127:64], 64'h0123456789ABCDEF);
        xfer(2'd2, 64'hCAFEF00D_5555AAAA, 3, 0);
        xfer(2'd0, 64'h00000000_FFFFFFFF, 0, 1);
        xfer(2'd0, 64'h22222222_11111111, 0, 0);
        chk("reg0_after_abort", d_out[63:0], 64'h2222222211111111);
        xfer(2'd0, 64'h33333333_44444444, 1, 2);
        xfer(2'd3, 64'h0BADF00D_0BADF00D, 1, 0);

        // Reset during the second beat of a write to a register that holds data.
        xfer(2'd1, 64'hDEADBEEF_00000000, 0, 0);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 2'd1;
        bus.wr_data  = 32'h12345678;
        tick();
        bus.wr_data  = 32'h9ABCDEF0;
        reset        = 1'b1;
        tick();
        clear_model();
        bus.wr_valid = 1'b0;
        chk("ready_rst_mid", 64'(bus.wr_ready), 64'(0));
        chk("busy_rst_mid", 64'(busy), 64'(0));
        chk_regs("rst_mid");
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 64'(bus.wr_ready), 64'(1));
        tick();
        chk("busy_after_rst", 64'(busy), 64'(0));
        chk("done_after_rst", 64'(bus.wr_done), 64'(0));
        chk_regs("after_rst");

        // Reset landing in the COMMIT cycle suppresses update and pulse.
        xfer(2'd2, 64'h7777777766666666, 0, 0);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 2'd0;
        bus.wr_data  = 32'hAAAA0000;
        tick();
        bus.wr_data  = 32'hBBBB1111;
        tick();
        bus.wr_valid = 1'b0;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        chk("done_rst_commit", 64'(bus.wr_done), 64'(0));
        chk_regs("rst_commit");
        tick();
        chk("done_rst_commit2", 64'(bus.wr_done), 64'(0));

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            int m;
            m = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            xfer(2'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)), m);
            if ($urandom_range(0, 1) == 1) tick();
        end
        chk_regs("random_end");

`ifdef REGBANK_READBACK_EN
        begin
            logic [63:0] old_v;
            rd_addr = 2'd1;
            old_v   = mdl[1];
            tick();
            chk("rd_pre", rd_data, old_v);
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 2'd1;
            bus.wr_data  = 32'hA5A5A5A5;
            tick();
            tick();
            bus.wr_valid = 1'b0;
            chk("rd_commit", rd_data, old_v);
            tick();
            mdl[1] = 64'hA5A5A5A5A5A5A5A5;
            chk("rd_commit_p1", rd_data, old_v);
            chk("done_rd", 64'(bus.wr_done), 64'(1));
            tick();
            chk("rd_commit_p2", rd_data, mdl[1]);
            rd_addr = 2'd3;
            tick();
            chk("rd_oor", rd_data, 64'(0));
            rd_addr = 2'd2;
            tick();
            chk("rd_reg2", rd_data, mdl[2]);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/register_bank_beat_wr.md
Name: register_bank_beat_wr

Overview:
- Parametrised bank of NUM_REGS registers, each REG_WIDTH bits wide, loaded over a narrower BUS_WIDTH write bus.
- Each register write is a multi-beat transfer with a valid/ready handshake. Beats collect in a shadow buffer, and the target register is updated atomically only after the last beat.
- Successor to the fixed 3x64-bit enable-register bank. It sits between the datapath/control bus and any consumer that needs wide configuration or operand registers.

Parameters:
- NUM_REGS, 3, number of registers in the bank (>=1).
- REG_WIDTH, 64, width of each register.
- BUS_WIDTH, 32, write-bus width. REG_WIDTH must be an integer multiple of it.
- Derived localparams, not overridable:
  - BEATS = REG_WIDTH/BUS_WIDTH.
  - ADDR_W = max(1, clog2(NUM_REGS)).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  beat valid.
- wr_ready  out  1  bank can accept a beat.
- wr_addr  in  ADDR_W  target register; sampled on the first beat only.
- wr_data  in  BUS_WIDTH  beat data.
- wr_abort  in  1  discard the partially collected write.
- wr_done  out  1  one-cycle pulse: register updated.
- wr_err  out  1  one-cycle pulse: write targeted an out-of-range address and was dropped.
- busy  out  1  high when state != IDLE.
- d_out  out  NUM_REGS*REG_WIDTH  all registers, flat; register i at [i*REG_WIDTH +: REG_WIDTH].

Behaviour:
- Reset (synchronous, active-high):
  - All registers, the shadow buffer and the beat counter go to 0.
  - State goes to IDLE; wr_done, wr_err and busy go to 0.
  - wr_ready is held 0 while reset is high.
- Accept rule: a beat is accepted when wr_valid && wr_ready.
  - wr_ready = 1 in IDLE and FILL, 0 in COMMIT.
- Beat packing: beat k (k = 0..BEATS-1) is stored at shadow[k*BUS_WIDTH +: BUS_WIDTH], so beat 0 is the LSB slice.
- FSM, IDLE:
  - On an accepted beat: latch wr_addr, store beat 0, beat_cnt <= 1.
  - Next state is COMMIT if BEATS == 1, otherwise FILL.
- FSM, FILL:
  - Each accepted beat is stored at beat_cnt and beat_cnt increments.
  - On the beat where beat_cnt == BEATS-1, go to COMMIT.
  - wr_addr is ignored on non-first beats.
  - Gaps (wr_valid low) are allowed; state is held.
- FSM, COMMIT (exactly one cycle):
  - At the closing edge, reg[addr] <= shadow if addr < NUM_REGS, and wr_done <= 1.
  - Otherwise no register changes and wr_err <= 1.
  - Next state is IDLE.
- Latency: first beat accepted at cycle t, last at t+BEATS-1, COMMIT at t+BEATS. New d_out and the wr_done pulse appear at t+BEATS+1. The next first beat can be accepted from t+BEATS+1.
- Atomicity: d_out of the target register never shows a partially written value.
- Abort:
  - In FILL, wr_abort returns the FSM to IDLE next cycle; the shadow is cleared and no register changes.
  - If wr_abort and wr_valid are high in the same FILL cycle, abort wins and the beat is discarded (wr_ready stays high).
  - wr_abort is ignored in IDLE and COMMIT.
- Reset mid-transfer: the transfer is lost and all registers clear. A reset during COMMIT suppresses the update and the pulse.
- wr_done and wr_err are never high together.

Optional Feature:
- Macro: REGBANK_READBACK_EN.
- Defined: adds ports rd_addr (in, ADDR_W) and rd_data (out, REG_WIDTH).
  - rd_data is registered: 1-cycle latency from rd_addr.
  - An out-of-range rd_addr returns 0; reset value is 0.
  - Reading the register being committed returns the old value in the COMMIT cycle and the new value after.
- Undefined: neither port exists; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE=2'd0, FILL=2'd1, COMMIT=2'd2.
  - Default width constants: REG_WIDTH 64, BUS_WIDTH 32.
- Sub-module register_word_r_en: one REG_WIDTH register with synchronous active-high reset and load enable. It is instantiated NUM_REGS times via generate, with load = commit && addr == i.

Test Plan:
- Reset, then write addr 1 with beats 0x89ABCDEF, 0x01234567 on consecutive cycles -> COMMIT on the 3rd cycle; on the 4th, reg1 = 0x0123456789ABCDEF with a wr_done pulse; reg0 and reg2 = 0.
- Write addr 2 with a 3-cycle gap between beats -> busy high throughout, reg2 unchanged until the cycle after COMMIT, then exactly one wr_done.
- Write addr 0: beat 0 = 0xFFFFFFFF, then wr_abort, then a full write of 0x11111111, 0x22222222 -> reg0 = 0x2222222211111111; no wr_done from the aborted transfer.
- Write to addr 3 (NUM_REGS=3) -> single wr_err pulse, no wr_done, all registers unchanged.
- Assert reset during the second beat of a write to addr 1 that already holds 0xDEADBEEF00000000 -> reg1 = 0 after reset; the FSM resumes in IDLE with wr_ready high the cycle after reset deasserts.
- With REGBANK_READBACK_EN defined: rd_addr = 1 held during a commit of 0xA5A5A5A5A5A5A5A5 -> rd_data shows the old value in the COMMIT+1 cycle and the new value one cycle later; rd_addr = 3 -> rd_data = 0.
